sd_read_arbiter: RTL and testbench

//  Shares the single SD_SPI block-read datapath between two requesters: the tile loader (video) and the

---
 rtl/sd_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sd_read_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_read_arbiter
// Brief    : Shares the SD_SPI block-read path between the audio streamer and
//            the tile loader; issues the read, counts and steers returned bytes.
// Revision : 1.0 - initial release
// ============================================================================
module sd_read_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int BLOCK_BYTES    = 512,
    parameter int IDX_W          = 9,
    parameter int AUD_MAX_STREAK = 3,
    parameter int TIMEOUT        = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              MasterCLK,
    input  logic              Reset,
    input  logic              TileReq,
    input  logic [ADDR_W-1:0] TileAddr,
    output logic              TileGnt,
    output logic              TileWe,
    output logic              TileDone,
    input  logic              AudReq,
    input  logic [ADDR_W-1:0] AudAddr,
    output logic              AudGnt,
    output logic              AudWe,
    output logic              AudDone,
    output logic              SD_Start,
    output logic              SD_Abort,
    output logic [ADDR_W-1:0] SD_Addr,
    input  logic              SD_Valid,
    input  logic [7:0]        SD_Data,
    output logic [7:0]        OutData,
    output logic [IDX_W-1:0]  OutIndex,
    output logic              Error
);

    localparam int                c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_IDLE     = 2'd0;
    localparam logic [c_ST_W-1:0] c_ISSUE    = 2'd1;
    localparam logic [c_ST_W-1:0] c_STREAM   = 2'd2;

    localparam int                 c_STK_W    = (AUD_MAX_STREAK < 1) ? 1 : $clog2(AUD_MAX_STREAK + 1);
    localparam logic [c_STK_W-1:0] c_STK_MAX  = c_STK_W'(AUD_MAX_STREAK);
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [TO_W-1:0]    c_WD_LIMIT = TO_W'(TIMEOUT - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic               r_owner_aud;
    logic               r_gnt;
    logic               r_start;
    logic               r_we;
    logic               r_done;
    logic               r_error;
    logic               r_abort;
    logic [ADDR_W-1:0]  r_sd_addr;
    logic [7:0]         r_out_data;
    logic [IDX_W-1:0]   r_out_index;
    logic [IDX_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_wd;
    logic [c_STK_W-1:0] r_streak;

    logic               w_any_req;
    logic               w_grant;
    logic               w_aud_win;
    logic               w_streaming;
    logic               w_take;
    logic               w_last;
    logic               w_expire;
    logic [c_STK_W-1:0] w_streak_inc;

    // Audio wins ties until it has taken AUD_MAX_STREAK grants in a row over a waiting tile.
    assign w_any_req    = TileReq | AudReq;
    assign w_aud_win    = AudReq & (~TileReq | (r_streak != c_STK_MAX));
    assign w_grant      = (r_state == c_IDLE) & w_any_req;
    assign w_streak_inc = (r_streak == c_STK_MAX) ? r_streak : r_streak + c_STK_W'(1);

    // The Done cycle is still spent in STREAM so Gnt covers it and no byte is taken.
    assign w_streaming  = (r_state == c_STREAM) & ~r_done;
    assign w_take       = w_streaming & SD_Valid;
    assign w_last       = w_take & (r_cnt == c_LAST_IDX);
    assign w_expire     = w_streaming & ~SD_Valid & (r_wd == c_WD_LIMIT);

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_any_req) w_state_nxt = c_ISSUE;
            c_ISSUE:  w_state_nxt = c_STREAM;
            c_STREAM: if (r_done) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            r_owner_aud <= 1'b0;
            r_gnt       <= 1'b0;
            r_start     <= 1'b0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_abort     <= 1'b0;
            r_sd_addr   <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_cnt       <= '0;
            r_wd        <= '0;
            r_streak    <= '0;
        end else begin
            r_start <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_abort <= 1'b0;

            if (r_done) begin
                r_gnt <= 1'b0;
            end

            if (w_grant) begin
                r_owner_aud <= w_aud_win;
                r_sd_addr   <= w_aud_win ? AudAddr : TileAddr;
                r_gnt       <= 1'b1;
                r_start     <= 1'b1;
                r_cnt       <= '0;
                r_wd        <= '0;
                if (w_aud_win && TileReq) begin
                    r_streak <= w_streak_inc;
                end else begin
                    r_streak <= '0;
                end
            end

            if (w_take) begin
                r_we        <= 1'b1;
                r_out_data  <= SD_Data;
                r_out_index <= r_cnt;
                r_wd        <= '0;
                if (!w_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_streaming && !w_expire) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_last) begin
                r_done <= 1'b1;
            end

            if (w_expire) begin
                r_done  <= 1'b1;
                r_error <= 1'b1;
                r_abort <= 1'b1;
            end
        end
    end

    assign TileGnt  = r_gnt  & ~r_owner_aud;
    assign TileWe   = r_we   & ~r_owner_aud;
    assign TileDone = r_done & ~r_owner_aud;
    assign AudGnt   = r_gnt  &  r_owner_aud;
    assign AudWe    = r_we   &  r_owner_aud;
    assign AudDone  = r_done &  r_owner_aud;
    assign SD_Start = r_start;
    assign SD_Abort = r_abort;
    assign SD_Addr  = r_sd_addr;
    assign OutData  = r_out_data;
    assign OutIndex = r_out_index;
    assign Error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sd_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_read_arbiter
// Brief    : Self-checking bench for sd_read_arbiter: cycle model plus directed
//            literal expectations for arbitration, streaming, watchdog, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_read_arbiter;

    localparam int ADDR_W  = 24;
    localparam int BLOCK   = 512;
    localparam int IDX_W   = 9;
    localparam int MAXS    = 3;
    localparam int TIMEOUT = 64;
    localparam int TO_W    = 8;

    logic              MasterCLK = 1'b0;
    logic              Reset;
    logic              TileReq, AudReq, SD_Valid;
    logic [ADDR_W-1:0] TileAddr, AudAddr;
    logic [7:0]        SD_Data;
    logic              TileGnt, TileWe, TileDone, AudGnt, AudWe, AudDone;
    logic              SD_Start, SD_Abort, Error;
    logic [ADDR_W-1:0] SD_Addr;
    logic [7:0]        OutData;
    logic [IDX_W-1:0]  OutIndex;

    sd_read_arbiter #(
        .ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK), .IDX_W(IDX_W),
        .AUD_MAX_STREAK(MAXS), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .MasterCLK(MasterCLK), .Reset(Reset),
        .TileReq(TileReq), .TileAddr(TileAddr), .TileGnt(TileGnt), .TileWe(TileWe), .TileDone(TileDone),
        .AudReq(AudReq), .AudAddr(AudAddr), .AudGnt(AudGnt), .AudWe(AudWe), .AudDone(AudDone),
        .SD_Start(SD_Start), .SD_Abort(SD_Abort), .SD_Addr(SD_Addr),
        .SD_Valid(SD_Valid), .SD_Data(SD_Data),
        .OutData(OutData), .OutIndex(OutIndex), .Error(Error)
    );

    always #5 MasterCLK = ~MasterCLK;

    // Reference model: one transaction at a time, described by byte count and quiet time.
    bit              m_ready, m_busy, m_aud, m_fresh, m_closing;
    bit              e_start, e_we, e_done, e_err, e_abort;
    int              m_got, m_quiet, m_streak;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]      e_data;
    logic [IDX_W-1:0] e_idx;

    always @(posedge MasterCLK) begin
        e_start = 0; e_we = 0; e_done = 0; e_err = 0; e_abort = 0;
        if (Reset) begin
            m_ready = 1; m_busy = 0; m_aud = 0; m_fresh = 0; m_closing = 0;
            m_got = 0; m_quiet = 0; m_streak = 0; m_addr = '0; e_data = '0; e_idx = '0;
        end else if (!m_busy) begin
            if (AudReq || TileReq) begin
                m_aud = AudReq && !(TileReq && m_streak == MAXS);
                if (m_aud && TileReq) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else m_streak = 0;
                m_addr = m_aud ? AudAddr : TileAddr;
                m_busy = 1; m_fresh = 1; e_start = 1; m_got = 0; m_quiet = 0;
            end
        end else if (m_fresh) begin
            m_fresh = 0;
        end else if (m_closing) begin
            m_busy = 0; m_closing = 0;
        end else if (SD_Valid) begin
            e_we = 1; e_data = SD_Data; e_idx = IDX_W'(m_got);
            m_got++; m_quiet = 0;
            if (m_got == BLOCK) begin e_done = 1; m_closing = 1; end
        end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin e_done = 1; e_err = 1; e_abort = 1; m_closing = 1; end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_tile_we, n_aud_we, n_done, n_err;
    int start_cyc, done_cyc, last_we_cyc, last_idx, first_idx;
    bit seen_start, seen_done, start_aud, done_we, done_ea, first_pending;
    logic [ADDR_W-1:0] start_addr, obs_addr;
    logic [8:0]  obs_ctrl;
    logic [16:0] obs_out;
    int g_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Compare the current cycle against the model on the negedge, update monitors, advance.
    task automatic cycle();
        logic [8:0] exp_ctrl;
        @(negedge MasterCLK);
        obs_ctrl = {TileGnt, TileWe, TileDone, AudGnt, AudWe, AudDone, SD_Start, SD_Abort, Error};
        obs_addr = SD_Addr;
        obs_out  = {OutData, OutIndex};
        if (m_ready) begin
            exp_ctrl = {m_busy && !m_aud, e_we && !m_aud, e_done && !m_aud,
                        m_busy && m_aud,  e_we && m_aud,  e_done && m_aud,
                        e_start, e_abort, e_err};
            check("ctrl", obs_ctrl, exp_ctrl);
            check("sd_addr", obs_addr, m_addr);
            check("out_data_index", obs_out, {e_data, e_idx});
        end
        seen_start = SD_Start;
        if (SD_Start) begin start_cyc = cyc; start_addr = SD_Addr; start_aud = AudGnt; end
        if (TileWe) n_tile_we++;
        if (AudWe)  n_aud_we++;
        if (TileWe || AudWe) begin
            last_idx = int'(OutIndex); last_we_cyc = cyc;
            if (first_pending) begin first_idx = int'(OutIndex); first_pending = 0; end
        end
        seen_done = TileDone | AudDone;
        if (seen_done) begin
            n_done++; done_cyc = cyc; done_we = TileWe | AudWe; done_ea = Error & SD_Abort;
        end
        if (Error) n_err++;
        @(posedge MasterCLK);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (seen_start) break;
        end
        if (!seen_start) check("start_timeout", seen_start, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (seen_done) break;
        end
        if (!seen_done) check("done_timeout", seen_done, 1);
    endtask

    // n strobes, each preceded by gap-1 idle cycles.
    task automatic send(input int n, input int gap, input int seed);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < gap - 1; j++) begin
                SD_Valid = 1'b0;
                cycle();
            end
            SD_Valid = 1'b1;
            SD_Data  = 8'(g_idx * 13 + seed);
            g_idx++;
            cycle();
        end
        SD_Valid = 1'b0;
    endtask

    initial begin
        int r, base, ebase, dbase;
        logic [7:0] order;
        n_tile_we = 0; n_aud_we = 0; n_done = 0; n_err = 0; first_pending = 0;
        Reset = 1'b1; TileReq = 1'b0; AudReq = 1'b0; SD_Valid = 1'b0; SD_Data = '0;
        TileAddr = '0; AudAddr = '0;
        @(posedge MasterCLK);
        #1;
        cycle();
        cycle();
        check("reset_ctrl", obs_ctrl, 0);
        check("reset_addr", obs_addr, 0);
        check("reset_out", obs_out, 0);
        Reset = 1'b0;
        cycle();

        // T1: audio-only block, strobe every 4 cycles
        AudAddr = 24'h000140; AudReq = 1'b1; r = cyc;
        wait_start(10);
        AudReq = 1'b0;
        check("t1_start_latency", start_cyc - r, 1);
        check("t1_start_addr", start_addr, 24'h000140);
        base = n_aud_we; g_idx = 0;
        send(BLOCK, 4, 1);
        wait_done(10);
        check("t1_aud_we_count", n_aud_we - base, 512);
        check("t1_last_index", last_idx, 511);
        check("t1_done_with_we", done_we, 1);

        // T2: both requesters held, expect A,A,A,T,A,A,A,T
        TileAddr = 24'h000AAA; AudAddr = 24'h000555; TileReq = 1'b1; AudReq = 1'b1;
        order = '0;
        for (int k = 0; k < 8; k++) begin
            wait_start(10);
            order = {order[6:0], start_aud};
            if (k == 7) begin TileReq = 1'b0; AudReq = 1'b0; end
            g_idx = 0;
            send(BLOCK, 1, k);
            wait_done(5);
        end
        check("t2_grant_order", order, 8'hEE);

        // T3: tile block stalls after byte 100
        TileAddr = 24'h000123; TileReq = 1'b1;
        wait_start(10);
        TileReq = 1'b0;
        base = n_tile_we; g_idx = 0;
        send(101, 1, 3);
        wait_done(TIMEOUT + 10);
        check("t3_tile_we_count", n_tile_we - base, 101);
        check("t3_abort_err_no_we", {done_ea, done_we}, 2'b10);
        check("t3_timeout_delay", done_cyc - last_we_cyc, TIMEOUT);
        AudAddr = 24'h000200; AudReq = 1'b1;
        wait_start(10);
        AudReq = 1'b0;
        base = n_aud_we; ebase = n_err; g_idx = 0;
        send(BLOCK, 1, 4);
        wait_done(5);
        check("t3_next_we_count", n_aud_we - base, 512);
        check("t3_next_no_error", n_err - ebase, 0);

        // T4: reset in the middle of a tile read
        TileAddr = 24'h000777; TileReq = 1'b1;
        wait_start(10);
        TileReq = 1'b0;
        dbase = n_done; g_idx = 0;
        send(200, 1, 5);
        SD_Valid = 1'b1; SD_Data = 8'h5A; Reset = 1'b1;
        cycle();
        Reset = 1'b0; SD_Valid = 1'b0;
        cycle();
        check("t4_ctrl_after_reset", obs_ctrl, 0);
        check("t4_addr_after_reset", obs_addr, 0);
        check("t4_out_after_reset", obs_out, 0);
        repeat (20) cycle();
        check("t4_no_done", n_done - dbase, 0);
        TileReq = 1'b1;
        wait_start(10);
        TileReq = 1'b0;
        base = n_tile_we; first_pending = 1; g_idx = 0;
        send(BLOCK, 1, 6);
        wait_done(5);
        check("t4_first_index", first_idx, 0);
        check("t4_tile_we_count", n_tile_we - base, 512);

        // T5: strobes while idle/issuing are dropped; strobes at watchdog expiry are kept
        base = n_aud_we + n_tile_we;
        for (int k = 0; k < 5; k++) begin
            SD_Valid = 1'b1; SD_Data = 8'(k);
            cycle();
            SD_Valid = 1'b0;
            cycle();
        end
        check("t5_no_we_in_idle", n_aud_we + n_tile_we - base, 0);
        AudAddr = 24'h000999; AudReq = 1'b1;
        cycle();
        AudReq = 1'b0; SD_Valid = 1'b1; SD_Data = 8'hFF;
        cycle();
        SD_Valid = 1'b0;
        check("t5_start_seen", seen_start, 1);
        base = n_aud_we; ebase = n_err; g_idx = 0;
        send(5, 1, 7);
        send(3, TIMEOUT, 7);
        send(BLOCK - 8, 1, 7);
        wait_done(5);
        check("t5_no_error_at_expiry", n_err - ebase, 0);
        check("t5_aud_we_count", n_aud_we - base, 512);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
